// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_rom_arbiter
//  Purpose  : Round-robin arbiter sharing one synchronous sprite ROM read
//             port among N_REQ pixel generators. At most one ROM read is
//             issued per clock. Each returned word is routed back to the
//             requester that issued it. The round-robin pointer returns to 0
//             on every frame start, so the grant order repeats each frame.
//  Ports    : clk         - pixel clock, rising edge
//             rst_n       - asynchronous active-low reset
//             frame_start - one-cycle pulse, clears the round-robin pointer
//             req         - per-requester request, held until granted
//             addr        - flattened request addresses, i at [i*ADDR_W +: ADDR_W]
//             gnt         - registered one-hot grant pulse
//             rom_en      - registered ROM read enable
//             rom_addr    - registered ROM address
//             rom_data    - ROM output word
//             rd_valid    - one-hot owner of the word on rd_data
//             rd_data     - registered copy of rom_data
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_rom_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 12,
    parameter int ROM_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   addr,
    output logic [N_REQ-1:0]          gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [N_REQ-1:0]          rd_valid,
    output logic [DATA_W-1:0]         rd_data
);

    localparam int                 c_ptr_w    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(N_REQ - 1);
    localparam logic [c_ptr_w:0]   c_ptr_lim  = (c_ptr_w + 1)'(N_REQ - 1);
    localparam logic [c_ptr_w:0]   c_n_req    = (c_ptr_w + 1)'(N_REQ);

    // Registered state
    logic [c_ptr_w-1:0] r_ptr;
    // r_tag[0] is the grant register itself; r_tag[ROM_LAT] lines up with
    // the cycle in which rom_data carries the word for that grant.
    logic [N_REQ-1:0]   r_tag [ROM_LAT+1];
    logic               r_rom_en;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [N_REQ-1:0]   r_rd_valid;
    logic [DATA_W-1:0]  r_rd_data;

    // Combinational arbitration
    logic [N_REQ-1:0]   w_elig;
    logic [N_REQ-1:0]   w_rot;
    logic               w_found;
    logic [c_ptr_w-1:0] w_off;
    logic [c_ptr_w:0]   w_sum;
    logic [c_ptr_w-1:0] w_win;
    logic [N_REQ-1:0]   w_win_onehot;
    logic [ADDR_W-1:0]  w_win_addr;
    logic [c_ptr_w-1:0] w_ptr_next;

    // The requester granted this cycle is masked so its held req is not
    // granted twice for the same address.
    assign w_elig = req & ~r_tag[0];

    // Rotate so that bit k corresponds to requester (ptr + k) mod N_REQ.
    assign w_rot = N_REQ'({w_elig, w_elig} >> r_ptr);

    // Lowest set bit of the rotated vector is the winner's distance from ptr.
    always_comb begin
        w_found = 1'b0;
        w_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_found = 1'b1;
                w_off   = c_ptr_w'(k);
            end
        end
    end

    // Undo the rotation with an explicit wrap; N_REQ need not be a power of 2.
    always_comb begin
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum > c_ptr_lim) begin
            w_sum = w_sum - c_n_req;
        end
        w_win = w_sum[c_ptr_w-1:0];
    end

    always_comb begin
        w_win_onehot = '0;
        w_win_addr   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == c_ptr_w'(i)) begin
                w_win_onehot[i] = 1'b1;
                w_win_addr      = addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_ptr_next = (w_win == c_ptr_last) ? '0 : w_win + c_ptr_w'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
            for (int j = 0; j <= ROM_LAT; j++) begin
                r_tag[j] <= '0;
            end
        end else begin
            r_tag[0] <= w_found ? w_win_onehot : '0;
            for (int j = 1; j <= ROM_LAT; j++) begin
                r_tag[j] <= r_tag[j-1];
            end

            r_rom_en <= w_found;
            if (w_found) begin
                r_rom_addr <= w_win_addr;
            end

            // Frame start wins over the winner's pointer advance; the grant
            // on this edge has already been chosen from the old pointer.
            if (frame_start) begin
                r_ptr <= '0;
            end else if (w_found) begin
                r_ptr <= w_ptr_next;
            end

            r_rd_valid <= r_tag[ROM_LAT];
            if (|r_tag[ROM_LAT]) begin
                r_rd_data <= rom_data;
            end
        end
    end

    assign gnt      = r_tag[0];
    assign rom_en   = r_rom_en;
    assign rom_addr = r_rom_addr;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_rom_arbiter
//  Purpose  : Self-checking bench for sprite_rom_arbiter. Directed scenarios
//             followed by randomized requester traffic, all compared against
//             a transaction-level reference model (round-robin search on an
//             integer pointer plus a queue of pending ROM returns).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_rom_arbiter;

    localparam int N_REQ   = 4;
    localparam int ADDR_W  = 17;
    localparam int DATA_W  = 12;
    localparam int ROM_LAT = 1;

    logic                    clk;
    logic                    rst_n;
    logic                    frame_start;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ-1:0]        gnt;
    logic                    rom_en;
    logic [ADDR_W-1:0]       rom_addr;
    logic [DATA_W-1:0]       rom_data;
    logic [N_REQ-1:0]        rd_valid;
    logic [DATA_W-1:0]       rd_data;

    logic [ADDR_W-1:0]       a_arr [N_REQ];

    sprite_rom_arbiter #(
        .N_REQ  (N_REQ),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .ROM_LAT(ROM_LAT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .req        (req),
        .addr       (addr),
        .gnt        (gnt),
        .rom_en     (rom_en),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            addr[i*ADDR_W +: ADDR_W] = a_arr[i];
        end
    end

    // ROM contents: a fixed scramble of the address.
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = ({15'd0, a} * 32'd37) ^ ({15'd0, a} >> 5);
        return x[DATA_W-1:0];
    endfunction

    // Synchronous ROM with ROM_LAT cycles from enable edge to data.
    logic [DATA_W-1:0] rom_pipe [ROM_LAT];
    always @(posedge clk) begin
        if (rom_en) rom_pipe[0] <= rom_word(rom_addr);
        for (int j = 1; j < ROM_LAT; j++) rom_pipe[j] <= rom_pipe[j-1];
    end
    assign rom_data = rom_pipe[ROM_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int                due;
        int                who;
        logic [DATA_W-1:0] data;
    } ret_t;

    ret_t              rq [$];
    int                m_ptr;
    logic [N_REQ-1:0]  m_gnt;
    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    int                cyc;
    int                n_cmp;
    int                n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: predict from current inputs, advance, compare all outputs.
    task automatic step();
        logic [N_REQ-1:0] elig;
        logic [N_REQ-1:0] ev;
        int               w;
        ret_t             r;
        elig = req & ~m_gnt;
        w    = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && elig[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        end
        if (w >= 0) begin
            r.due  = cyc + 2 + ROM_LAT;
            r.who  = w;
            r.data = rom_word(a_arr[w]);
            rq.push_back(r);
            m_gnt  = N_REQ'(1) << w;
            m_en   = 1'b1;
            m_addr = a_arr[w];
            m_ptr  = (w + 1) % N_REQ;
        end else begin
            m_gnt = '0;
            m_en  = 1'b0;
        end
        if (frame_start) m_ptr = 0;

        @(posedge clk); #1;
        cyc++;

        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("rom_en", 32'(rom_en), 32'(m_en));
        if (m_en) chk("rom_addr", 32'(rom_addr), 32'(m_addr));

        ev = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            ev = N_REQ'(1) << rq[0].who;
            chk("rd_valid", 32'(rd_valid), 32'(ev));
            chk("rd_data", 32'(rd_data), 32'(rq[0].data));
            void'(rq.pop_front());
        end else begin
            chk("rd_valid", 32'(rd_valid), 32'(ev));
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_rom_en"}, 32'(rom_en), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        #1;
        m_gnt  = '0;
        m_ptr  = 0;
        m_en   = 1'b0;
        m_addr = '0;
        rq.delete();
        check_zero("rst");
        repeat (n) begin
            @(posedge clk); #1;
            cyc++;
            check_zero("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    task automatic drain(input int n);
        req = '0;
        repeat (n) step();
    endtask

    // Randomized requesters obeying the protocol: hold until granted, then
    // drop or present a new address in the grant cycle.
    task automatic rand_requesters();
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && m_gnt[i]) begin
                if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                else a_arr[i] = ADDR_W'($urandom);
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                req[i]   = 1'b1;
                a_arr[i] = ADDR_W'($urandom);
            end
        end
        frame_start = ($urandom_range(0, 19) == 0);
    endtask

    initial begin
        logic [N_REQ-1:0] seq [5];
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        rst_n = 1'b1;
        frame_start = 1'b0;
        req = '1;
        for (int i = 0; i < N_REQ; i++) a_arr[i] = ADDR_W'(32'h100 * (i + 1));
        #2;

        // Reset with every requester active, then first grant goes to 0.
        do_reset(3);
        step();
        chk("first_gnt", 32'(gnt), 32'h1);
        chk("first_addr", 32'(rom_addr), 32'h100);

        // Full contention: granted requester re-requests with a new address.
        seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < N_REQ; i++) if (m_gnt[i]) a_arr[i] = ADDR_W'($urandom);
            step();
            chk("contention_gnt", 32'(gnt), 32'(seq[s]));
            chk("contention_en", 32'(rom_en), 32'd1);
        end
        drain(5);

        // Realign pointer to 0, then a single continuous requester.
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        req = 4'b0100;
        a_arr[2] = 17'h00ABC;
        for (int s = 1; s <= 8; s++) begin
            step();
            chk("single_gnt", 32'(gnt), (s % 2 == 1) ? 32'h4 : 32'h0);
            chk("single_rdv", 32'(rd_valid), (s >= 3 && s % 2 == 1) ? 32'h4 : 32'h0);
            if (s >= 3 && s % 2 == 1) chk("single_rdd", 32'(rd_data), 32'(rom_word(17'h00ABC)));
        end
        drain(4);

        // Wrap and skip: pointer sits at 3 after granting 2.
        req = 4'b0101;
        step();
        chk("wrap_gnt0", 32'(gnt), 32'h1);
        req = 4'b0100;
        step();
        chk("wrap_gnt2", 32'(gnt), 32'h4);
        drain(4);

        // frame_start on the edge that grants requester 1.
        req = 4'b0010;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("fs_gnt1", 32'(gnt), 32'h2);
        req = 4'b0111;
        step();
        chk("fs_next", 32'(gnt), 32'h1);
        drain(6);

        // Reset one cycle after a grant: the read must never return.
        req = 4'b0100;
        step();
        chk("midrst_gnt", 32'(gnt), 32'h4);
        req = '0;
        do_reset(2);
        drain(4);
        req = 4'b1001;
        step();
        chk("midrst_ptr", 32'(gnt), 32'h1);
        req = 4'b1000;
        step();
        drain(4);

        // Randomized traffic with occasional frame starts.
        for (int s = 0; s < 400; s++) begin
            rand_requesters();
            step();
        end
        frame_start = 1'b0;
        drain(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
